db_req_arbiter: RTL and testbench

//  Shares the single DB lookup/update port between two requesters: port 0 (network
//  RX lookups) and port 1 (control-plane insert/delete). Grants one request per

---
 rtl/db_req_arbiter_pkg.sv | 30 +++
 rtl/db_req_arbiter_if.sv | 45 ++++
 rtl/db_arb_tagq.sv | 58 +++++
 rtl/db_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_db_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/db_req_arbiter_pkg.sv
// Shared definitions for the DB request arbiter.
//   - DB op codes and response status codes, shared with the DB controller.
//   - Default key length and the arbiter FSM state type.
//   - Saturating increment used by the optional statistics counters.
package db_req_arbiter_pkg;

  localparam int unsigned KEY_LEN = 96;

  // Request op codes.
  localparam logic [3:0] OP_LOOKUP = 4'h1;
  localparam logic [3:0] OP_INSERT = 4'h2;
  localparam logic [3:0] OP_DELETE = 4'h3;

  // Response status codes.
  localparam logic [3:0] SUSPECTION = 4'd1;
  localparam logic [3:0] ARREST     = 4'd2;
  localparam logic [3:0] FILTERED   = 4'd3;
  localparam logic [3:0] EXPIRED    = 4'd4;

  typedef enum logic [1:0] {
    ARB_P0,
    ARB_P1,
    ARB_DRAIN
  } arb_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/db_req_arbiter_if.sv
// Signal bundle between the two requesters / DB controller and the arbiter.
//   p0_*, p1_*     : requester valid/ready/key/flag
//   db_*           : request strobe to, and in-order response from, the DB controller
//   r0/r1_valid    : response routed back to the issuing requester, with shared r_flag
//   cfg_pause      : drain request; quiesced / err_orphan are arbiter status
// Modports: master = environment side (requesters + DB controller), slave = arbiter.
interface db_req_arbiter_if #(
  parameter int unsigned KEY_SIZE  = 96,
  parameter int unsigned FLAG_SIZE = 4
);
  logic                 p0_valid;
  logic                 p0_ready;
  logic [KEY_SIZE-1:0]  p0_key;
  logic [FLAG_SIZE-1:0] p0_flag;
  logic                 p1_valid;
  logic                 p1_ready;
  logic [KEY_SIZE-1:0]  p1_key;
  logic [FLAG_SIZE-1:0] p1_flag;
  logic                 db_valid;
  logic [KEY_SIZE-1:0]  db_key;
  logic [FLAG_SIZE-1:0] db_flag;
  logic                 db_rsp_valid;
  logic [FLAG_SIZE-1:0] db_rsp_flag;
  logic                 r0_valid;
  logic                 r1_valid;
  logic [FLAG_SIZE-1:0] r_flag;
  logic                 cfg_pause;
  logic                 quiesced;
  logic                 err_orphan;

  modport master (
    output p0_valid, p0_key, p0_flag, p1_valid, p1_key, p1_flag,
    output db_rsp_valid, db_rsp_flag, cfg_pause,
    input  p0_ready, p1_ready, db_valid, db_key, db_flag,
    input  r0_valid, r1_valid, r_flag, quiesced, err_orphan
  );

  modport slave (
    input  p0_valid, p0_key, p0_flag, p1_valid, p1_key, p1_flag,
    input  db_rsp_valid, db_rsp_flag, cfg_pause,
    output p0_ready, p1_ready, db_valid, db_key, db_flag,
    output r0_valid, r1_valid, r_flag, quiesced, err_orphan
  );

endinterface

// File: rtl/db_arb_tagq.sv
// 1-bit-wide synchronous FIFO holding the requester ID of each in-flight DB request.
//   clk, rst_n : clock, synchronous active-low reset (discards all entries)
//   push, din  : enqueue one ID
//   pop, dout  : dequeue; dout is the head, read combinationally
//   count      : occupancy 0..DEPTH; empty / full flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module db_arb_tagq #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/db_req_arbiter.sv
// Arbitrates the single DB lookup/update port between port 0 (network RX lookups) and
// port 1 (control-plane insert/delete). One grant per cycle; the granted request is issued
// to the DB controller one cycle later and its requester ID is queued so the in-order DB
// response can be routed back. cfg_pause stops granting and reports quiesced once drained.
//   clk, rst_n         : clock, synchronous active-low reset
//   bus (slave)        : requester, DB controller and pause/status signals
//   stat_* (optional)  : 32-bit saturating grant / queue-full counters
// Optional feature macro: DB_ARB_STATS_EN adds stat_p0_grants, stat_p1_grants and
// stat_full_cycles output ports.
module db_req_arbiter
  import db_req_arbiter_pkg::*;
#(
  parameter int unsigned KEY_SIZE   = KEY_LEN,
  parameter int unsigned FLAG_SIZE  = 4,
  parameter int unsigned MAX_OUTST  = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  db_req_arbiter_if.slave    bus
`ifdef DB_ARB_STATS_EN
  ,
  output logic [31:0]        stat_p0_grants,
  output logic [31:0]        stat_p1_grants,
  output logic [31:0]        stat_full_cycles
`endif
);
  localparam int unsigned CntW      = $clog2(MAX_OUTST) + 1;
  localparam logic [7:0]  StarveMax = 8'(STARVE_MAX);

  arb_state_e           state_q, state_d;
  logic [7:0]           starve_q, starve_d;
  logic                 can_grant;
  logic                 gnt0, gnt1;

  logic [CntW-1:0]      outst_cnt;
  logic                 tq_empty, tq_full, tq_dout, tq_pop, tq_push;

  logic                 db_valid_q;
  logic [KEY_SIZE-1:0]  db_key_q;
  logic [FLAG_SIZE-1:0] db_flag_q;
  logic                 r0_valid_q, r1_valid_q;
  logic [FLAG_SIZE-1:0] r_flag_q;
  logic                 quiesced_q;
  logic                 err_orphan_q;

  // Responses arriving with nothing outstanding are orphans and are not popped.
  assign tq_pop  = bus.db_rsp_valid && !tq_empty;
  assign tq_push = gnt0 || gnt1;

  db_arb_tagq #(
    .DEPTH (MAX_OUTST)
  ) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tq_push),
    .pop   (tq_pop),
    .din   (gnt1),
    .dout  (tq_dout),
    .count (outst_cnt),
    .empty (tq_empty),
    .full  (tq_full)
  );

  // Grant / next-state logic. A pop in the current cycle does not free a slot until the
  // next cycle, so a full queue always blocks granting.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    can_grant = rst_n && !bus.cfg_pause && (state_q != ARB_DRAIN) && !tq_full;

    unique case (state_q)
      ARB_P0: begin
        if (can_grant && bus.p0_valid) begin
          gnt0 = 1'b1;
          // Count only grants that made port 1 wait.
          starve_d = bus.p1_valid ? starve_q + 8'd1 : 8'd0;
          if (starve_d == StarveMax) begin
            state_d = ARB_P1;
          end
        end else if (can_grant && bus.p1_valid) begin
          gnt1     = 1'b1;
          starve_d = 8'd0;
        end
      end
      ARB_P1: begin
        if (can_grant && bus.p1_valid) begin
          gnt1     = 1'b1;
          starve_d = 8'd0;
          state_d  = ARB_P0;
        end else if (can_grant && bus.p0_valid) begin
          gnt0 = 1'b1;
        end
      end
      ARB_DRAIN: begin
        state_d  = ARB_P0;
        starve_d = 8'd0;
      end
      default: begin
        state_d  = ARB_P0;
        starve_d = 8'd0;
      end
    endcase

    // Pause wins from any state and holds the arbiter in drain.
    if (bus.cfg_pause) begin
      state_d = ARB_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_P0;
      starve_q     <= 8'd0;
      db_valid_q   <= 1'b0;
      db_key_q     <= '0;
      db_flag_q    <= '0;
      r0_valid_q   <= 1'b0;
      r1_valid_q   <= 1'b0;
      r_flag_q     <= '0;
      quiesced_q   <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      db_valid_q <= gnt0 || gnt1;
      if (gnt1) begin
        db_key_q  <= bus.p1_key;
        db_flag_q <= bus.p1_flag;
      end else if (gnt0) begin
        db_key_q  <= bus.p0_key;
        db_flag_q <= bus.p0_flag;
      end
      r0_valid_q <= tq_pop && !tq_dout;
      r1_valid_q <= tq_pop && tq_dout;
      if (tq_pop) begin
        r_flag_q <= bus.db_rsp_flag;
      end
      // Falls in the same edge that pause is released.
      quiesced_q <= bus.cfg_pause && (outst_cnt == '0);
      if (bus.db_rsp_valid && tq_empty) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

  assign bus.p0_ready   = gnt0;
  assign bus.p1_ready   = gnt1;
  assign bus.db_valid   = db_valid_q;
  assign bus.db_key     = db_key_q;
  assign bus.db_flag    = db_flag_q;
  assign bus.r0_valid   = r0_valid_q;
  assign bus.r1_valid   = r1_valid_q;
  assign bus.r_flag     = r_flag_q;
  assign bus.quiesced   = quiesced_q;
  assign bus.err_orphan = err_orphan_q;

`ifdef DB_ARB_STATS_EN
  logic [31:0] st_p0_q, st_p1_q, st_full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_p0_q   <= '0;
      st_p1_q   <= '0;
      st_full_q <= '0;
    end else begin
      st_p0_q   <= sat_inc32(st_p0_q, gnt0);
      st_p1_q   <= sat_inc32(st_p1_q, gnt1);
      st_full_q <= sat_inc32(st_full_q, (bus.p0_valid || bus.p1_valid) && tq_full);
    end
  end

  assign stat_p0_grants   = st_p0_q;
  assign stat_p1_grants   = st_p1_q;
  assign stat_full_cycles = st_full_q;
`endif

endmodule

// File: tb/tb_db_req_arbiter.sv
// Self-checking bench for db_req_arbiter: randomized and directed stimulus, a reference
// model of the arbitration rules, and a scoreboard monitor for issued requests/responses.
module tb_db_req_arbiter;
  import db_req_arbiter_pkg::*;

  localparam int unsigned KS = 96;
  localparam int unsigned FS = 4;
  localparam int unsigned MO = 16;
  localparam int unsigned SM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  db_req_arbiter_if #(.KEY_SIZE(KS), .FLAG_SIZE(FS)) bus ();

`ifdef DB_ARB_STATS_EN
  logic [31:0] s_p0, s_p1, s_full;
`endif

  db_req_arbiter #(
    .KEY_SIZE   (KS),
    .FLAG_SIZE  (FS),
    .MAX_OUTST  (MO),
    .STARVE_MAX (SM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DB_ARB_STATS_EN
    ,
    .stat_p0_grants   (s_p0),
    .stat_p1_grants   (s_p1),
    .stat_full_cycles (s_full)
`endif
  );

  typedef struct {
    logic [KS-1:0] key;
    logic [FS-1:0] flag;
    int            edge_n;
  } db_item_t;

  typedef struct {
    bit            port;
    logic [FS-1:0] flag;
    int            edge_n;
  } rsp_item_t;

  db_item_t  db_exp[$];
  rsp_item_t rsp_exp[$];

  // Reference model: requester IDs in flight, p0 streak while p1 waits, and flags.
  bit m_tags[$];
  int m_streak;
  bit m_owed;      // p1 is owed the next grant
  bit m_drain;     // paused, or just released and not yet granting
  bit m_quiesced;
  bit m_orphan;
  int cyc;

  int nchk;
  int nerr;

  logic [KS-1:0] fixed_key;
  logic [FS-1:0] fixed_flag;
  bit            use_fixed;
  logic [FS-1:0] rf_force;
  bit            rf_use;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // One clock cycle: drive inputs, check combinational readies, advance the model.
  task automatic step(input bit v0, input bit v1, input bit pause, input bit rsp,
                      input bit rstn);
    logic [KS-1:0] k0, k1;
    logic [FS-1:0] f0, f1, rf;
    bit ok, g0, g1, p;
    int n_out;
    k0 = {$urandom(), $urandom(), $urandom()};
    k1 = {$urandom(), $urandom(), $urandom()};
    f0 = FS'($urandom_range(0, 15));
    f1 = FS'($urandom_range(0, 15));
    rf = FS'($urandom_range(0, 15));
    if (use_fixed) begin
      k0 = fixed_key;
      f0 = fixed_flag;
    end
    if (rf_use) rf = rf_force;

    @(negedge clk);
    rst_n            = rstn;
    bus.p0_valid     = v0;
    bus.p0_key       = k0;
    bus.p0_flag      = f0;
    bus.p1_valid     = v1;
    bus.p1_key       = k1;
    bus.p1_flag      = f1;
    bus.db_rsp_valid = rsp;
    bus.db_rsp_flag  = rf;
    bus.cfg_pause    = pause;
    #2;

    n_out = m_tags.size();
    ok = rstn && !pause && !m_drain && (n_out < int'(MO));
    g0 = 1'b0;
    g1 = 1'b0;
    if (ok) begin
      if (m_owed) begin
        if (v1) g1 = 1'b1;
        else if (v0) g0 = 1'b1;
      end else begin
        if (v0) g0 = 1'b1;
        else if (v1) g1 = 1'b1;
      end
    end
    chk("p0_ready", 128'(bus.p0_ready), 128'(g0));
    chk("p1_ready", 128'(bus.p1_ready), 128'(g1));

    @(posedge clk);
    cyc++;
    if (!rstn) begin
      m_tags.delete();
      db_exp.delete();
      rsp_exp.delete();
      m_streak   = 0;
      m_owed     = 1'b0;
      m_drain    = 1'b0;
      m_quiesced = 1'b0;
      m_orphan   = 1'b0;
    end else begin
      m_quiesced = pause && (n_out == 0);
      if (rsp) begin
        if (m_tags.size() > 0) begin
          p = m_tags.pop_front();
          rsp_exp.push_back('{p, rf, cyc});
        end else begin
          m_orphan = 1'b1;
        end
      end
      if (g0) begin
        m_tags.push_back(1'b0);
        db_exp.push_back('{k0, f0, cyc});
      end
      if (g1) begin
        m_tags.push_back(1'b1);
        db_exp.push_back('{k1, f1, cyc});
      end
      if (pause) begin
        m_drain = 1'b1;
      end else if (m_drain) begin
        m_drain  = 1'b0;
        m_streak = 0;
        m_owed   = 1'b0;
      end else if (g1) begin
        m_streak = 0;
        m_owed   = 1'b0;
      end else if (g0 && !m_owed) begin
        m_streak = v1 ? m_streak + 1 : 0;
        if (m_streak == int'(SM)) m_owed = 1'b1;
      end
    end
  endtask

  // Scoreboard monitor: registered outputs sampled on the falling edge.
  initial begin : monitor
    db_item_t  d;
    rsp_item_t r;
    forever begin
      @(negedge clk);
      if (db_exp.size() > 0 && db_exp[0].edge_n == cyc) begin
        d = db_exp.pop_front();
        chk("db_valid", 128'(bus.db_valid), 128'(1'b1));
        chk("db_key", 128'(bus.db_key), 128'(d.key));
        chk("db_flag", 128'(bus.db_flag), 128'(d.flag));
      end else begin
        chk("db_valid_idle", 128'(bus.db_valid), 128'(1'b0));
      end
      if (rsp_exp.size() > 0 && rsp_exp[0].edge_n == cyc) begin
        r = rsp_exp.pop_front();
        chk("r0_valid", 128'(bus.r0_valid), 128'(!r.port));
        chk("r1_valid", 128'(bus.r1_valid), 128'(r.port));
        chk("r_flag", 128'(bus.r_flag), 128'(r.flag));
      end else begin
        chk("r_valid_idle", 128'({bus.r0_valid, bus.r1_valid}), 128'(2'b00));
      end
      chk("quiesced", 128'(bus.quiesced), 128'(m_quiesced));
      chk("err_orphan", 128'(bus.err_orphan), 128'(m_orphan));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin : stim
    int pause_left;
    bit pz;
    bus.p0_valid = 1'b0;  bus.p0_key = '0;  bus.p0_flag = '0;
    bus.p1_valid = 1'b0;  bus.p1_key = '0;  bus.p1_flag = '0;
    bus.db_rsp_valid = 1'b0;  bus.db_rsp_flag = '0;  bus.cfg_pause = 1'b0;
    use_fixed = 1'b0;  rf_use = 1'b0;
    fixed_key = 96'hC0A80001_0A000001_0035_0000;
    fixed_flag = OP_LOOKUP;
    rf_force = '0;

    // Requests during reset must not be accepted.
    repeat (3) step(1, 1, 0, 0, 0);

    // Single p0 lookup, status FILTERED 5 cycles later.
    use_fixed = 1'b1;
    step(1, 0, 0, 0, 1);
    use_fixed = 1'b0;
    repeat (4) step(0, 0, 0, 0, 1);
    rf_use = 1'b1;  rf_force = FILTERED;
    step(0, 0, 0, 1, 1);
    rf_use = 1'b0;
    repeat (2) step(0, 0, 0, 0, 1);

    // Both ports always valid: starvation guard, responses flowing.
    repeat (45) step(1, 1, 0, m_tags.size() > 0, 1);
    repeat (20) step(0, 0, 0, m_tags.size() > 0, 1);

    // Fill the tag queue, then free exactly one slot.
    repeat (22) step(1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 1);
    repeat (3) step(1, 1, 0, 0, 1);
    repeat (24) step(0, 0, 0, m_tags.size() > 0, 1);

    // Interleaved issue 0,1,1,0 with response flags 1..4.
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    rf_use = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rf_force = FS'(i);
      step(0, 0, 0, 1, 1);
    end
    rf_use = 1'b0;
    repeat (2) step(0, 0, 0, 0, 1);

    // Pause with 3 outstanding, drain, release.
    repeat (3) step(1, 0, 0, 0, 1);
    repeat (2) step(1, 1, 1, 0, 1);
    repeat (3) step(1, 1, 1, 1, 1);
    repeat (3) step(1, 1, 1, 0, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    repeat (20) step(0, 0, 0, m_tags.size() > 0, 1);

    // Randomized traffic with occasional pause bursts.
    pause_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (pause_left == 0 && $urandom_range(0, 99) == 0) pause_left = $urandom_range(5, 40);
      pz = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, pz,
           (m_tags.size() > 0) && ($urandom_range(0, 2) != 0), 1);
    end
    repeat (20) step(0, 0, 0, m_tags.size() > 0, 1);

    // Orphan response on an empty queue.
    step(0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, m_tags.size() > 0, 1);

    // Reset with 4 outstanding, then a late response becomes an orphan.
    repeat (4) step(1, 1, 0, 0, 1);
    repeat (2) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
